// File: rtl/dp_ram_be_clr.sv
// dp_ram_be_clr: simple dual-port RAM (one write port, one read port, one clock).
// Features: byte-enable writes, 1- or 2-clock read latency with a valid strobe,
// write-first forwarding on address collision, and a clear engine that zeroes
// the array after reset and on a clr pulse.
// Optional feature macro: RAM_PARITY_EN (per-lane even parity, rd_perr on mismatch).
module dp_ram_be_clr #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR   = 4,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   output logic                  busy,
   input  logic                  we,
   input  logic [ADDR-1:0]       wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [WIDTH/8-1:0]    wr_be,
   input  logic                  re,
   input  logic [ADDR-1:0]       rd_addr,
   output logic [WIDTH-1:0]      d_out,
   output logic                  rd_valid,
   output logic                  rd_perr
);

   localparam int unsigned BE_W    = WIDTH / 8;
   localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
   localparam logic [ADDR-1:0] LAST_C = ADDR'(DEPTH - 1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR-1:0]     r_ptr;
   logic [WIDTH-1:0]    r_mem [DEPTH];
`ifdef RAM_PARITY_EN
   logic [BE_W-1:0]     mem_par [DEPTH];
   logic [BE_W-1:0]     w_par_st;
`endif

   logic                w_idle;
   logic                w_wr_inr;
   logic                w_rd_inr;
   logic                w_wr_ok;
   logic                w_rd_ok;
   logic                w_fwd;
   logic [WIDTH-1:0]    w_rd_data;
   logic                w_rd_perr;

   assign w_idle   = (r_state == S_IDLE);
   assign w_wr_inr = ({1'b0, wr_addr} < DEPTH_C);
   assign w_rd_inr = ({1'b0, rd_addr} < DEPTH_C);
   assign w_wr_ok  = w_idle & we & w_wr_inr;
   assign w_rd_ok  = w_idle & re;
   assign w_fwd    = w_wr_ok & (wr_addr == rd_addr);

   // Clear sequencer: sweeps the pointer over the array, then idles until clr
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CLEAR;
         r_ptr   <= '0;
         busy    <= 1'b1;
      end else if (r_state == S_CLEAR) begin
         if (r_ptr == LAST_C) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            busy    <= 1'b0;
         end else begin
            r_ptr   <= r_ptr + 1'b1;
         end
      end else if (clr) begin
         r_state <= S_CLEAR;
         r_ptr   <= '0;
         busy    <= 1'b1;
      end
   end

   // Array update: clear sweep while busy, otherwise byte-lane writes
   always_ff @(posedge clk) begin
      if (!w_idle) begin
         r_mem[r_ptr] <= '0;
`ifdef RAM_PARITY_EN
         mem_par[r_ptr] <= '0;
`endif
      end else if (w_wr_ok) begin
         for (int k = 0; k < int'(BE_W); k++) begin
            if (wr_be[k]) begin
               r_mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
`ifdef RAM_PARITY_EN
               mem_par[wr_addr][k] <= ^wr_data[8*k +: 8];
`endif
            end
         end
      end
   end

   // Read lookup with write-first forwarding of the enabled lanes
   always_comb begin
      w_rd_data = '0;
      w_rd_perr = 1'b0;
`ifdef RAM_PARITY_EN
      w_par_st  = '0;
`endif
      if (w_rd_inr) begin
         w_rd_data = r_mem[rd_addr];
`ifdef RAM_PARITY_EN
         w_par_st  = mem_par[rd_addr];
`endif
         for (int k = 0; k < int'(BE_W); k++) begin
            if (w_fwd && wr_be[k]) begin
               w_rd_data[8*k +: 8] = wr_data[8*k +: 8];
`ifdef RAM_PARITY_EN
               w_par_st[k] = ^wr_data[8*k +: 8];
`endif
            end
         end
`ifdef RAM_PARITY_EN
         for (int k = 0; k < int'(BE_W); k++) begin
            if ((^w_rd_data[8*k +: 8]) != w_par_st[k]) begin
               w_rd_perr = 1'b1;
            end
         end
`endif
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [WIDTH-1:0] r_p1_data;
         logic             r_p1_vld;
         logic             r_p1_perr;

         // Two-stage read pipeline; d_out holds between completions
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_p1_data <= '0;
               r_p1_vld  <= 1'b0;
               r_p1_perr <= 1'b0;
               d_out     <= '0;
               rd_valid  <= 1'b0;
               rd_perr   <= 1'b0;
            end else begin
               r_p1_vld <= w_rd_ok;
               if (w_rd_ok) begin
                  r_p1_data <= w_rd_data;
                  r_p1_perr <= w_rd_perr;
               end
               rd_valid <= r_p1_vld;
               rd_perr  <= r_p1_vld & r_p1_perr;
               if (r_p1_vld) begin
                  d_out <= r_p1_data;
               end
            end
         end
      end else begin : g_lat1
         // Single-stage read register; d_out holds between completions
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               d_out    <= '0;
               rd_valid <= 1'b0;
               rd_perr  <= 1'b0;
            end else begin
               rd_valid <= w_rd_ok;
               rd_perr  <= w_rd_ok & w_rd_perr;
               if (w_rd_ok) begin
                  d_out <= w_rd_data;
               end
            end
         end
      end
   endgenerate

endmodule
